// File: rtl/ddr_rd_pkg.sv
// rtl/ddr_rd_pkg.sv - shared types and default sizes for the DDR read arbiter
package ddr_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DATA = 2'd2
  } rd_arb_state_t;

  localparam int PORT_NUM_DEF   = 4;
  localparam int ADDR_WIDTH_DEF = 27;
  localparam int LEN_WIDTH_DEF  = 16;
  localparam int DQ_WIDTH_DEF   = 32;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker, search starts after last grant
module rr_arbiter #(
  parameter int PORT_NUM = 4
) (
  input  logic [PORT_NUM-1:0] req_i,
  input  logic [PORT_NUM-1:0] last_i,
  output logic [PORT_NUM-1:0] grant_o
);

  logic seen;
  logic found;

  // Walk the request vector twice; only ports after the last-granted bit are
  // eligible on the first lap, so the second lap wraps around up to and
  // including the last-granted port itself. An empty last vector starts at 0.
  always_comb begin
    grant_o = '0;
    seen    = (last_i == '0);
    found   = 1'b0;
    for (int j = 0; j < 2 * PORT_NUM; j++) begin
      if (seen && !found && req_i[j % PORT_NUM]) begin
        grant_o[j % PORT_NUM] = 1'b1;
        found                 = 1'b1;
      end
      if (last_i[j % PORT_NUM]) begin
        seen = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddr_rd_arbiter.sv
// rtl/ddr_rd_arbiter.sv - round-robin sharing of the DDR read master among line-fetch cells
module ddr_rd_arbiter
  import ddr_rd_pkg::*;
#(
  parameter int PORT_NUM   = PORT_NUM_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int LEN_WIDTH  = LEN_WIDTH_DEF,
  parameter int DQ_WIDTH   = DQ_WIDTH_DEF
) (
  input  logic                             ddr_clk,
  input  logic                             ddr_rst,
  input  logic [PORT_NUM-1:0]              port_rreq,
  input  logic [PORT_NUM*ADDR_WIDTH-1:0]   port_raddr,
  input  logic [PORT_NUM*LEN_WIDTH-1:0]    port_rd_len,
  output logic [8*DQ_WIDTH-1:0]            port_rdata,
  output logic [PORT_NUM-1:0]              port_rdata_en,
  output logic [PORT_NUM-1:0]              port_rdone,
  output logic                             ddr_rreq,
  output logic [ADDR_WIDTH-1:0]            ddr_raddr,
  output logic [LEN_WIDTH-1:0]             ddr_rd_len,
  input  logic                             ddr_rrdy,
  input  logic [8*DQ_WIDTH-1:0]            ddr_rdata,
  input  logic                             ddr_rdata_en,
  input  logic                             ddr_rdone,
  output logic [PORT_NUM-1:0]              cur_grant,
  output logic                             drop_err
);

  localparam int DW = 8 * DQ_WIDTH;

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_REQ  = ST_REQ;
  localparam logic [1:0] S_DATA = ST_DATA;

  localparam logic [PORT_NUM-1:0] LAST_RST = {1'b1, {(PORT_NUM-1){1'b0}}};

  logic [1:0]            state_q, state_d;
  logic [PORT_NUM-1:0]   pending_q, pending_d;
  logic [ADDR_WIDTH-1:0] addr_q [PORT_NUM];
  logic [ADDR_WIDTH-1:0] addr_d [PORT_NUM];
  logic [LEN_WIDTH-1:0]  len_q  [PORT_NUM];
  logic [LEN_WIDTH-1:0]  len_d  [PORT_NUM];
  logic [PORT_NUM-1:0]   last_q, last_d;
  logic [PORT_NUM-1:0]   grant_q, grant_d;
  logic                  rreq_q, rreq_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [LEN_WIDTH-1:0]  rlen_q, rlen_d;
  logic [DW-1:0]         rdata_q, rdata_d;
  logic [PORT_NUM-1:0]   rdata_en_q, rdata_en_d;
  logic [PORT_NUM-1:0]   rdone_q, rdone_d;
  logic                  drop_q, drop_d;

  logic [PORT_NUM-1:0]   pick;
  logic                  accept;

  rr_arbiter #(
    .PORT_NUM (PORT_NUM)
  ) u_rr_arbiter (
    .req_i   (pending_q),
    .last_i  (last_q),
    .grant_o (pick)
  );

  // Pending-queue capture and the IDLE/REQ/DATA sequencing of the DDR port.
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    addr_d     = addr_q;
    len_d      = len_q;
    last_d     = last_q;
    grant_d    = grant_q;
    rreq_d     = rreq_q;
    raddr_d    = raddr_q;
    rlen_d     = rlen_q;
    rdata_d    = rdata_q;
    rdata_en_d = '0;
    rdone_d    = '0;
    drop_d     = drop_q;

    accept = (state_q == S_REQ) && rreq_q && ddr_rrdy;

    // A request landing on the accept cycle of its own port refills the slot
    // that is being freed, so it is captured rather than dropped.
    for (int i = 0; i < PORT_NUM; i++) begin
      if (port_rreq[i]) begin
        if (!pending_q[i] || (accept && grant_q[i])) begin
          pending_d[i] = 1'b1;
          addr_d[i]    = port_raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
          len_d[i]     = port_rd_len[i*LEN_WIDTH +: LEN_WIDTH];
        end else begin
          drop_d = 1'b1;
        end
      end else if (accept && grant_q[i]) begin
        pending_d[i] = 1'b0;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (|pick) begin
          grant_d = pick;
          rreq_d  = 1'b1;
          state_d = S_REQ;
          for (int i = 0; i < PORT_NUM; i++) begin
            if (pick[i]) begin
              raddr_d = addr_q[i];
              rlen_d  = len_q[i];
            end
          end
        end
      end
      S_REQ: begin
        if (accept) begin
          rreq_d  = 1'b0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (ddr_rdata_en) begin
          rdata_d    = ddr_rdata;
          rdata_en_d = grant_q;
        end
        if (ddr_rdone) begin
          rdone_d = grant_q;
          last_d  = grant_q;
          grant_d = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge ddr_clk) begin
    if (ddr_rst) begin
      state_q    <= S_IDLE;
      pending_q  <= '0;
      last_q     <= LAST_RST;
      grant_q    <= '0;
      rreq_q     <= 1'b0;
      raddr_q    <= '0;
      rlen_q     <= '0;
      rdata_q    <= '0;
      rdata_en_q <= '0;
      rdone_q    <= '0;
      drop_q     <= 1'b0;
      for (int i = 0; i < PORT_NUM; i++) begin
        addr_q[i] <= '0;
        len_q[i]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      last_q     <= last_d;
      grant_q    <= grant_d;
      rreq_q     <= rreq_d;
      raddr_q    <= raddr_d;
      rlen_q     <= rlen_d;
      rdata_q    <= rdata_d;
      rdata_en_q <= rdata_en_d;
      rdone_q    <= rdone_d;
      drop_q     <= drop_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
    end
  end

  assign port_rdata    = rdata_q;
  assign port_rdata_en = rdata_en_q;
  assign port_rdone    = rdone_q;
  assign ddr_rreq      = rreq_q;
  assign ddr_raddr     = raddr_q;
  assign ddr_rd_len    = rlen_q;
  assign cur_grant     = grant_q;
  assign drop_err      = drop_q;

endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// tb/tb_ddr_rd_arbiter.sv - directed self-checking bench for ddr_rd_arbiter
module tb_ddr_rd_arbiter;

  localparam int PN = 4;
  localparam int AW = 27;
  localparam int LW = 16;
  localparam int DQ = 32;
  localparam int DW = 8 * DQ;

  logic              clk = 1'b0;
  logic              rst;
  logic [PN-1:0]     port_rreq;
  logic [PN*AW-1:0]  port_raddr;
  logic [PN*LW-1:0]  port_rd_len;
  logic [DW-1:0]     port_rdata;
  logic [PN-1:0]     port_rdata_en;
  logic [PN-1:0]     port_rdone;
  logic              ddr_rreq;
  logic [AW-1:0]     ddr_raddr;
  logic [LW-1:0]     ddr_rd_len;
  logic              ddr_rrdy;
  logic [DW-1:0]     ddr_rdata;
  logic              ddr_rdata_en;
  logic              ddr_rdone;
  logic [PN-1:0]     cur_grant;
  logic              drop_err;

  int errors = 0;
  int checks = 0;
  int beats [PN];
  int dones [PN];
  logic [31:0]   seq = 32'h1000;
  logic [DW-1:0] samp_data;

  typedef struct {
    int          port;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    int          wait_cyc;
    bit          done_last;
  } vec_t;

  vec_t tbl [10];

  ddr_rd_arbiter #(
    .PORT_NUM   (PN),
    .ADDR_WIDTH (AW),
    .LEN_WIDTH  (LW),
    .DQ_WIDTH   (DQ)
  ) dut (
    .ddr_clk       (clk),
    .ddr_rst       (rst),
    .port_rreq     (port_rreq),
    .port_raddr    (port_raddr),
    .port_rd_len   (port_rd_len),
    .port_rdata    (port_rdata),
    .port_rdata_en (port_rdata_en),
    .port_rdone    (port_rdone),
    .ddr_rreq      (ddr_rreq),
    .ddr_raddr     (ddr_raddr),
    .ddr_rd_len    (ddr_rd_len),
    .ddr_rrdy      (ddr_rrdy),
    .ddr_rdata     (ddr_rdata),
    .ddr_rdata_en  (ddr_rdata_en),
    .ddr_rdone     (ddr_rdone),
    .cur_grant     (cur_grant),
    .drop_err      (drop_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) samp_data <= ddr_rdata;

  always @(negedge clk) begin
    if (port_rdata_en != '0) begin
      chk("rdata_en_onehot", {255'd0, $onehot(port_rdata_en)}, 256'd1);
      chk("rdata_value", port_rdata, samp_data);
      for (int i = 0; i < PN; i++) if (port_rdata_en[i]) beats[i]++;
    end
    if (port_rdone != '0) begin
      for (int i = 0; i < PN; i++) if (port_rdone[i]) dones[i]++;
    end
  end

  task automatic set_port(input int p, input logic [AW-1:0] a, input logic [LW-1:0] l);
    port_rreq[p]            = 1'b1;
    port_raddr[p*AW +: AW]  = a;
    port_rd_len[p*LW +: LW] = l;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    port_rreq    = '0;
    ddr_rrdy     = 1'b0;
    ddr_rdata_en = 1'b0;
    ddr_rdone    = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rreq"},    ddr_rreq, 0);
    chk({tag, "_raddr"},   ddr_raddr, 0);
    chk({tag, "_rdlen"},   ddr_rd_len, 0);
    chk({tag, "_grant"},   cur_grant, 0);
    chk({tag, "_rdata"},   port_rdata, 0);
    chk({tag, "_rdataen"}, port_rdata_en, 0);
    chk({tag, "_rdone"},   port_rdone, 0);
    chk({tag, "_droperr"}, drop_err, 0);
  endtask

  task automatic wait_req(input vec_t v);
    int n = 0;
    logic [PN-1:0] g;
    g = 4'b0001 << v.port;
    while (ddr_rreq !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("rreq_seen", ddr_rreq, 1);
    chk("grant", cur_grant, g);
    chk("raddr", ddr_raddr, v.addr);
    chk("rd_len", ddr_rd_len, v.len);
  endtask

  task automatic data_phase(input int p, input int len, input bit done_last);
    int b0, d0;
    logic [PN-1:0] g;
    g  = 4'b0001 << p;
    b0 = beats[p];
    d0 = dones[p];
    for (int b = 0; b < len; b++) begin
      ddr_rdata_en = 1'b1;
      ddr_rdata    = {8{seq}};
      seq++;
      ddr_rdone    = done_last && (b == len - 1);
      tick();
    end
    ddr_rdata_en = 1'b0;
    if (!done_last) begin
      ddr_rdone = 1'b1;
      tick();
    end
    ddr_rdone = 1'b0;
    chk("rdone_pulse", port_rdone, g);
    chk("grant_cleared", cur_grant, 0);
    tick();
    chk("beat_count", beats[p] - b0, len);
    chk("done_count", dones[p] - d0, 1);
  endtask

  task automatic serve(input vec_t v);
    wait_req(v);
    for (int w = 0; w < v.wait_cyc; w++) begin
      ddr_rrdy = 1'b0;
      tick();
      chk("bp_rreq", ddr_rreq, 1);
      chk("bp_raddr", ddr_raddr, v.addr);
      chk("bp_rdlen", ddr_rd_len, v.len);
    end
    ddr_rrdy = 1'b1;
    tick();
    ddr_rrdy = 1'b0;
    chk("rreq_dropped_after_accept", ddr_rreq, 0);
    data_phase(v.port, int'(v.len), v.done_last);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t c, d, e;
    int hi;
    int b0, d0;

    for (int i = 0; i < PN; i++) begin
      beats[i] = 0;
      dones[i] = 0;
      tbl[i]     = '{port: i, addr: 27'h0100000 + 27'(i * 64), len: 16'd4, wait_cyc: 0, done_last: (i % 2 == 1)};
      tbl[i + 4] = '{port: i, addr: 27'h0200000 + 27'(i * 64), len: 16'd4, wait_cyc: 0, done_last: (i % 2 == 0)};
    end
    tbl[8] = '{port: 2, addr: 27'h0ABCDE0, len: 16'd6, wait_cyc: 10, done_last: 1'b0};
    tbl[9] = '{port: 2, addr: 27'h0123400, len: 16'd3, wait_cyc: 2,  done_last: 1'b1};

    port_raddr   = '0;
    port_rd_len  = '0;
    ddr_rdata    = '0;
    do_reset();
    chk_all_zero("reset");

    // Single request, rrdy held high: request visible two cycles after the pulse.
    set_port(1, 27'h0001E00, 16'd180);
    ddr_rrdy = 1'b1;
    tick();
    port_rreq = '0;
    chk("single_t1_rreq", ddr_rreq, 0);
    tick();
    chk("single_t2_rreq", ddr_rreq, 1);
    chk("single_t2_raddr", ddr_raddr, 27'h0001E00);
    chk("single_t2_rdlen", ddr_rd_len, 16'd180);
    chk("single_t2_grant", cur_grant, 4'b0010);
    tick();
    ddr_rrdy = 1'b0;
    chk("single_accept_rreq", ddr_rreq, 0);
    data_phase(1, 180, 1'b0);

    // Fairness: all four ports together, twice; order 0,1,2,3 both rounds.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < PN; i++) set_port(i, tbl[r*4 + i].addr, tbl[r*4 + i].len);
      tick();
      port_rreq = '0;
      for (int i = 0; i < PN; i++) serve(tbl[r*4 + i]);
    end

    // Backpressure: rrdy low for 10 cycles while in REQ.
    set_port(2, tbl[8].addr, tbl[8].len);
    tick();
    port_rreq = '0;
    serve(tbl[8]);

    // Drop: second request on port 2 before grant is ignored.
    do_reset();
    set_port(2, tbl[9].addr, tbl[9].len);
    tick();
    set_port(2, 27'h0765400, 16'd9);
    tick();
    port_rreq = '0;
    chk("drop_err_set", drop_err, 1);
    serve(tbl[9]);
    hi = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (ddr_rreq) hi++;
    end
    chk("drop_single_burst", hi, 0);
    chk("drop_err_sticky", drop_err, 1);

    // Re-request of port 0 on its own accept cycle.
    do_reset();
    c = '{port: 0, addr: 27'h0040000, len: 16'd4, wait_cyc: 0, done_last: 1'b1};
    d = '{port: 0, addr: 27'h0050000, len: 16'd5, wait_cyc: 1, done_last: 1'b0};
    set_port(0, c.addr, c.len);
    tick();
    port_rreq = '0;
    wait_req(c);
    ddr_rrdy = 1'b1;
    set_port(0, d.addr, d.len);
    tick();
    port_rreq = '0;
    ddr_rrdy  = 1'b0;
    chk("rereq_accept_rreq", ddr_rreq, 0);
    chk("rereq_no_drop", drop_err, 0);
    data_phase(0, 4, 1'b1);
    chk("rereq_at_t2", ddr_rreq, 1);
    serve(d);
    chk("rereq_no_drop_end", drop_err, 0);

    // Reset after 50 of 180 beats; the rest of the burst is stray.
    e = '{port: 1, addr: 27'h0333300, len: 16'd180, wait_cyc: 0, done_last: 1'b1};
    set_port(1, e.addr, e.len);
    tick();
    port_rreq = '0;
    wait_req(e);
    ddr_rrdy = 1'b1;
    tick();
    ddr_rrdy = 1'b0;
    b0 = beats[1];
    d0 = dones[1];
    for (int b = 0; b < 50; b++) begin
      ddr_rdata_en = 1'b1;
      ddr_rdata    = {8{seq}};
      seq++;
      tick();
    end
    ddr_rdata_en = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all_zero("midrst");
    for (int b = 0; b < 130; b++) begin
      ddr_rdata_en = 1'b1;
      ddr_rdata    = {8{seq}};
      seq++;
      ddr_rdone    = (b == 129);
      tick();
    end
    ddr_rdata_en = 1'b0;
    ddr_rdone    = 1'b0;
    tick();
    tick();
    chk("midrst_beats", beats[1] - b0, 50);
    chk("midrst_dones", dones[1] - d0, 0);
    chk("midrst_grant", cur_grant, 0);
    chk("midrst_rreq", ddr_rreq, 0);
    chk("midrst_drop", drop_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
